// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell, one bit per clock.
// Operands shift out LSB first; the ripple carry is held in a flip-flop between bits.

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-2:0]   sreg;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   sum_nxt;

    fa u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // The newest bit enters at the MSB, so after WIDTH shifts bit 0 is at the LSB.
    assign sum_nxt = {fa_s, sreg};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        opa   <= A;
                        opb   <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    sreg  <= sum_nxt[WIDTH-1:1];
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        S     <= sum_nxt;
                        Cout  <= fa_co;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
